grid_ram_arbiter: RTL and testbench
===================================

Name: grid_ram_arbiter

Overview:
- Shares the single-port snake grid RAM (40x30 cells of 16x16 px, 1200 entries) between three requesters.
- Requesters, highest priority first: the video cell fetcher (driven from the 640x480 scan position), then two game masters, m0 (snake engine) and m1 (food placer).
- Video reads are always accepted. The game masters share the remaining cycles round-robin. All read data is returned with a fixed 2-cycle latency, tagged to its owner.

Parameters:
- ADDR_W, 11, grid RAM address width (covers 1200 cells)
- DATA_W, 4, cell content width

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- vid_req  in  1  video read request; always accepted
- vid_addr  in  ADDR_W  video read address
- vid_rdata  out  DATA_W  video read data
- vid_rvalid  out  1  vid_rdata valid (1-cycle pulse)
- m0_req  in  1  master 0 request; held until granted
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  request accepted this cycle (combinational)
- m0_rdata  out  DATA_W  master 0 read data
- m0_rvalid  out  1  m0_rdata valid (1-cycle pulse)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as m0, for master 1
- ram_en  out  1  RAM access enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read command

Behaviour:
- Arbitration happens in cycle N. The winning command is registered onto ram_* in N+1. RAM data returns on ram_rdata in N+2. The owner's rvalid is high and its rdata is valid in N+2.
- Priority: vid_req beats both masters. When vid_req=1 in a cycle, m0_gnt and m1_gnt are 0 for that cycle.
- No video request, single master requesting: that master is granted.
- No video request, both masters requesting: grant goes to the master not granted last. The last_grant register updates only on an actual master grant.
- Handshake: gnt is combinational from req, within the same cycle. A transfer occurs when req&&gnt. The master holds req, we, addr and wdata stable until gnt. Dropping req before gnt is legal; no access is issued.
- Writes produce no rvalid. Read-after-write to the same address from the same master, in consecutive grants, returns the new data (RAM write-first not required; ordering comes from serialization).
- Owner pipeline: 2-stage tag {valid, owner[1:0], is_read} per stage.
  - Stage 1 is the registered command.
  - Stage 2 drives rvalid selection.
  - rdata for all three owners is a direct fan-out of ram_rdata; only the selected rvalid asserts.
- Idle cycle (no grant): ram_en=0; ram_we=0; ram_addr and ram_wdata hold their previous values.
- Reset values:
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - All rvalid=0, both pipeline stages invalid.
  - All gnt=0 while reset is high.
  - last_grant=m1, so m0 wins the first conflict.
- Reset mid-operation: in-flight reads are discarded and no rvalid fires for commands accepted before reset.
- Video fetcher requirement: issue reads 2 cycles ahead of the pixel that uses the data. Video stalls cannot occur.

Optional Feature:
- Macro GRID_RAM_ARBITER_STATS_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - Counts cycles with (m0_req&&!m0_gnt)||(m1_req&&!m1_gnt); a single increment per cycle.
  - Saturates at 16'hFFFF; cleared to 0 by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then m0 read addr 5 (RAM model holds 4'hA at 5), no video -> m0_gnt same cycle; ram_en=1, ram_addr=5 next cycle; m0_rvalid=1, m0_rdata=4'hA two cycles after grant; m1_rvalid/vid_rvalid stay 0.
- vid_req held high 10 cycles while m1 requests a write (addr 7, data 3) -> m1_gnt=0 for all 10 cycles. Granted in the first cycle vid_req=0. RAM sees write addr 7 data 3 one cycle later. With STATS_EN, stall_cnt=10.
- m0 and m1 request continuously, no video, for 6 cycles -> grants alternate m0, m1, m0, m1, m0, m1 (m0 first after reset).
- Back-to-back mixed traffic: video reads addr 1, 2, then m0 read addr 3 -> vid_rvalid, vid_rvalid, m0_rvalid on consecutive cycles, each with correct data and owner.
- m0 read granted, reset asserted the next cycle for 1 cycle -> no m0_rvalid ever fires; ram_en=0 during and after reset until a new grant.
- m1 write addr 9 data 6, then m1 read addr 9 -> m1_rvalid with m1_rdata=6; exactly one rvalid pulse.

Source files
------------

// File: rtl/grid_ram_arbiter.sv
// grid_ram_arbiter: shares the single-port snake grid RAM between the video fetcher and two game masters.
// Build option GRID_RAM_ARBITER_STATS_EN adds a saturating master stall counter on port stall_cnt.
`timescale 1ns/1ps
module grid_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
`ifdef GRID_RAM_ARBITER_STATS_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] OWN_VID = 2'd0;
    localparam logic [1:0] OWN_M0  = 2'd1;
    localparam logic [1:0] OWN_M1  = 2'd2;

    logic       last_m1;    // 1 when m1 took the most recent master grant
    logic       m0_win;
    logic       m1_win;
    logic       any_gnt;
    logic       s1_valid;
    logic       s1_read;
    logic [1:0] s1_owner;
    logic       s2_valid;
    logic       s2_read;
    logic [1:0] s2_owner;

    always_comb begin
        m0_win = m0_req && (!m1_req || last_m1);
        m1_win = m1_req && (!m0_req || !last_m1);
    end

    assign m0_gnt  = !reset && !vid_req && m0_win;
    assign m1_gnt  = !reset && !vid_req && m1_win;
    assign any_gnt = vid_req || m0_gnt || m1_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            last_m1   <= 1'b1;
            s1_valid  <= 1'b0;
            s1_read   <= 1'b0;
            s1_owner  <= OWN_VID;
            s2_valid  <= 1'b0;
            s2_read   <= 1'b0;
            s2_owner  <= OWN_VID;
        end else begin
            ram_en   <= any_gnt;
            ram_we   <= (m0_gnt && m0_we) || (m1_gnt && m1_we);
            s1_valid <= any_gnt;
            // address and write data hold their last values on idle cycles
            if (vid_req) begin
                ram_addr <= vid_addr;
                s1_owner <= OWN_VID;
                s1_read  <= 1'b1;
            end else if (m0_gnt) begin
                ram_addr  <= m0_addr;
                ram_wdata <= m0_wdata;
                s1_owner  <= OWN_M0;
                s1_read   <= !m0_we;
                last_m1   <= 1'b0;
            end else if (m1_gnt) begin
                ram_addr  <= m1_addr;
                ram_wdata <= m1_wdata;
                s1_owner  <= OWN_M1;
                s1_read   <= !m1_we;
                last_m1   <= 1'b1;
            end
            s2_valid <= s1_valid;
            s2_read  <= s1_read;
            s2_owner <= s1_owner;
        end
    end

    assign vid_rdata  = ram_rdata;
    assign m0_rdata   = ram_rdata;
    assign m1_rdata   = ram_rdata;
    assign vid_rvalid = s2_valid && s2_read && (s2_owner == OWN_VID);
    assign m0_rvalid  = s2_valid && s2_read && (s2_owner == OWN_M0);
    assign m1_rvalid  = s2_valid && s2_read && (s2_owner == OWN_M1);

`ifdef GRID_RAM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (((m0_req && !m0_gnt) || (m1_req && !m1_gnt)) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// Self-checking bench for grid_ram_arbiter: directed scenarios plus a randomized run against a
// behavioural priority/round-robin model with a memory image and per-cycle expected responses.
`timescale 1ns/1ps
module tb_grid_ram_arbiter;
    localparam int AW = 11;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic          vid_rvalid;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
`ifdef GRID_RAM_ARBITER_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem     [0:2047];
    logic [DW-1:0] ref_mem [0:2047];
    logic          mem_loaded = 1'b0;

    always #5 clk = ~clk;

    grid_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
`ifdef GRID_RAM_ARBITER_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // single-port RAM with 1-cycle read latency; image is cell = addr[3:0] ^ 4'hF
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= DW'(i) ^ 4'hF;
            mem_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vid_req = 1'b0;
        m0_req  = 1'b0;
        m0_we   = 1'b0;
        m1_req  = 1'b0;
        m1_we   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        m0_req = 1'b1;
        m1_req = 1'b1;
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_m0_gnt: got %b want 0", m0_gnt); end
        n_checks++; if (m1_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_m1_gnt: got %b want 0", m1_gnt); end
        tick();
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b0) begin n_errors++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== '0) begin n_errors++; $display("FAIL rst_ram_addr: got %0h want 0", ram_addr); end
        n_checks++; if (ram_wdata !== '0) begin n_errors++; $display("FAIL rst_ram_wdata: got %0h want 0", ram_wdata); end
        n_checks++; if ({vid_rvalid, m0_rvalid, m1_rvalid} !== 3'b000) begin
            n_errors++; $display("FAIL rst_rvalid: got %b want 000", {vid_rvalid, m0_rvalid, m1_rvalid});
        end
`ifdef GRID_RAM_ARBITER_STATS_EN
        n_checks++; if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        idle_inputs();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = DW'(i) ^ 4'hF;
    endtask

    task automatic test_m0_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd5;
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL rd_m0_gnt: got %b want 1", m0_gnt); end
        n_checks++; if (m1_gnt !== 1'b0) begin n_errors++; $display("FAIL rd_m1_gnt: got %b want 0", m1_gnt); end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({ram_en, ram_we} !== 2'b10) begin n_errors++; $display("FAIL rd_ram_cmd: got en/we %b want 10", {ram_en, ram_we}); end
        n_checks++; if (ram_addr !== 11'd5) begin n_errors++; $display("FAIL rd_ram_addr: got %0d want 5", ram_addr); end
        n_checks++; if (m0_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_early_rvalid: got %b want 0", m0_rvalid); end
        tick();
        @(negedge clk);
        n_checks++; if (m0_rvalid !== 1'b1) begin n_errors++; $display("FAIL rd_m0_rvalid: got %b want 1", m0_rvalid); end
        n_checks++; if (m0_rdata !== 4'hA) begin n_errors++; $display("FAIL rd_m0_rdata: got %0h want a", m0_rdata); end
        n_checks++; if ({vid_rvalid, m1_rvalid} !== 2'b00) begin n_errors++; $display("FAIL rd_other_rvalid: got %b want 00", {vid_rvalid, m1_rvalid}); end
        tick();
        @(negedge clk);
        n_checks++; if (m0_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_pulse_end: got %b want 0", m0_rvalid); end
        n_checks++; if (ram_en !== 1'b0 || ram_addr !== 11'd5) begin
            n_errors++; $display("FAIL rd_idle_hold: got en %b addr %0d want en 0 addr 5", ram_en, ram_addr);
        end
    endtask

    task automatic test_video_priority();
        apply_reset();
        vid_req = 1'b1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'd7; m1_wdata = 4'd3;
        for (int i = 0; i < 10; i++) begin
            vid_addr = AW'($urandom_range(1199, 0));
            @(negedge clk);
            n_checks++; if (m1_gnt !== 1'b0 || m0_gnt !== 1'b0) begin
                n_errors++; $display("FAIL vid_block_%0d: got m0/m1 gnt %b%b want 00", i, m0_gnt, m1_gnt);
            end
            tick();
        end
        vid_req = 1'b0;
        @(negedge clk);
        n_checks++; if (m1_gnt !== 1'b1) begin n_errors++; $display("FAIL vid_release_gnt: got %b want 1", m1_gnt); end
        tick();
        m1_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 11'd7, 4'd3}) begin
            n_errors++; $display("FAIL vid_m1_write: got en %b we %b addr %0d data %0d want 1 1 7 3", ram_en, ram_we, ram_addr, ram_wdata);
        end
`ifdef GRID_RAM_ARBITER_STATS_EN
        n_checks++; if (stall_cnt !== 16'd10) begin n_errors++; $display("FAIL vid_stall_cnt: got %0d want 10", stall_cnt); end
`endif
        ref_mem[7] = 4'd3;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m0_addr = AW'($urandom_range(1199, 0));
            m1_addr = AW'($urandom_range(1199, 0));
            @(negedge clk);
            n_checks++; if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
                n_errors++; $display("FAIL rr_%0d: got m0/m1 gnt %b%b want %b%b", i, m0_gnt, m1_gnt, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            if (k == 0) begin vid_req = 1'b1; vid_addr = 11'd1; end
            if (k == 1) begin vid_req = 1'b1; vid_addr = 11'd2; end
            if (k == 2) begin m0_req = 1'b1; m0_addr = 11'd3; end
            @(negedge clk);
            if (k == 2) begin
                n_checks++; if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL b2b_m0_gnt: got %b want 1", m0_gnt); end
            end
            n_checks++; if ({vid_rvalid, m0_rvalid, m1_rvalid} !== {(k == 2 || k == 3), (k == 4), 1'b0}) begin
                n_errors++; $display("FAIL b2b_rvalid_%0d: got v/m0/m1 %b%b%b", k, vid_rvalid, m0_rvalid, m1_rvalid);
            end
            if (k == 2 || k == 3) begin
                n_checks++; if (vid_rdata !== ref_mem[k - 1]) begin
                    n_errors++; $display("FAIL b2b_vid_data_%0d: got %0h want %0h", k, vid_rdata, ref_mem[k - 1]);
                end
            end
            if (k == 4) begin
                n_checks++; if (m0_rdata !== ref_mem[3]) begin n_errors++; $display("FAIL b2b_m0_data: got %0h want %0h", m0_rdata, ref_mem[3]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd4;
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL rmid_gnt: got %b want 1", m0_gnt); end
        tick();
        m0_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (m0_rvalid !== 1'b0 || ram_en !== 1'b0) begin
                n_errors++; $display("FAIL rmid_%0d: got rvalid %b ram_en %b want 0 0", i, m0_rvalid, ram_en);
            end
            tick();
        end
    endtask

    task automatic test_raw();
        int n_m1 = 0;
        int n_other = 0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'd9; m1_wdata = 4'd6;
        @(negedge clk);
        n_checks++; if (m1_gnt !== 1'b1) begin n_errors++; $display("FAIL raw_wr_gnt: got %b want 1", m1_gnt); end
        tick();
        m1_we = 1'b0;
        @(negedge clk);
        n_checks++; if (m1_gnt !== 1'b1) begin n_errors++; $display("FAIL raw_rd_gnt: got %b want 1", m1_gnt); end
        tick();
        m1_req = 1'b0;
        ref_mem[9] = 4'd6;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m1_rvalid === 1'b1) begin
                n_m1++;
                n_checks++; if (m1_rdata !== 4'd6) begin n_errors++; $display("FAIL raw_data: got %0d want 6", m1_rdata); end
            end
            if (vid_rvalid === 1'b1 || m0_rvalid === 1'b1) n_other++;
            tick();
        end
        n_checks++; if (n_m1 != 1 || n_other != 0) begin
            n_errors++; $display("FAIL raw_pulses: got m1 %0d other %0d want 1 0", n_m1, n_other);
        end
    endtask

    task automatic test_random();
        int ev [4];
        int eo [4];
        logic [DW-1:0] ed [4];
        int last_m1 = 1;
        int winner = -1;
        int e_stall = 0;
        int s;
        logic e_en = 1'b0, e_we = 1'b0;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_wdata = '0;
        logic [DW-1:0] got;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        logic w_we;
        for (int i = 0; i < 4; i++) ev[i] = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            vid_req  = ($urandom_range(9, 0) < 3);
            vid_addr = AW'($urandom_range(1199, 0));
            if (m0_req && winner != 1) begin
                if ($urandom_range(9, 0) == 0) m0_req = 1'b0;
            end else begin
                m0_req = ($urandom_range(1, 0) == 1); m0_we = ($urandom_range(2, 0) == 0);
                m0_addr = AW'($urandom_range(15, 0)); m0_wdata = DW'($urandom_range(15, 0));
            end
            if (m1_req && winner != 2) begin
                if ($urandom_range(9, 0) == 0) m1_req = 1'b0;
            end else begin
                m1_req = ($urandom_range(1, 0) == 1); m1_we = ($urandom_range(2, 0) == 0);
                m1_addr = AW'($urandom_range(15, 0)); m1_wdata = DW'($urandom_range(15, 0));
            end
            @(negedge clk);
            // who wins: video always, else the lone master, else the one not served last
            if (vid_req) winner = 0;
            else if (m0_req && m1_req) winner = (last_m1 == 1) ? 1 : 2;
            else if (m0_req) winner = 1;
            else if (m1_req) winner = 2;
            else winner = -1;
            n_checks++; if (m0_gnt !== (winner == 1) || m1_gnt !== (winner == 2)) begin
                n_errors++; $display("FAIL rnd_gnt c%0d: got m0/m1 %b%b want winner %0d", c, m0_gnt, m1_gnt, winner);
            end
            n_checks++; if (ram_en !== e_en || ram_we !== e_we || ram_addr !== e_addr || (e_we && ram_wdata !== e_wdata)) begin
                n_errors++; $display("FAIL rnd_ram c%0d: got en %b we %b addr %0h data %0h want %b %b %0h %0h",
                                     c, ram_en, ram_we, ram_addr, ram_wdata, e_en, e_we, e_addr, e_wdata);
            end
            s = c % 4;
            n_checks++; if ({vid_rvalid, m0_rvalid, m1_rvalid} !== {(ev[s] == 1 && eo[s] == 0), (ev[s] == 1 && eo[s] == 1), (ev[s] == 1 && eo[s] == 2)}) begin
                n_errors++; $display("FAIL rnd_rvalid c%0d: got v/m0/m1 %b%b%b want slot %0d owner %0d", c, vid_rvalid, m0_rvalid, m1_rvalid, ev[s], eo[s]);
            end
            if (ev[s] == 1) begin
                got = (eo[s] == 0) ? vid_rdata : (eo[s] == 1) ? m0_rdata : m1_rdata;
                n_checks++; if (got !== ed[s]) begin n_errors++; $display("FAIL rnd_rdata c%0d: got %0h want %0h owner %0d", c, got, ed[s], eo[s]); end
            end
            ev[s] = 0;
            if ((m0_req && winner != 1) || (m1_req && winner != 2)) e_stall = (e_stall < 65535) ? e_stall + 1 : e_stall;
            e_en = (winner >= 0);
            e_we = 1'b0;
            if (winner >= 0) begin
                w_addr = (winner == 0) ? vid_addr : (winner == 1) ? m0_addr : m1_addr;
                w_we   = (winner == 1) ? m0_we : (winner == 2) ? m1_we : 1'b0;
                w_data = (winner == 1) ? m0_wdata : m1_wdata;
                e_addr = w_addr;
                e_we   = w_we;
                if (winner != 0) begin
                    e_wdata = w_data;
                    last_m1 = (winner == 2) ? 1 : 0;
                end
                if (w_we) ref_mem[w_addr] = w_data;
                else begin
                    ev[(c + 2) % 4] = 1;
                    eo[(c + 2) % 4] = winner;
                    ed[(c + 2) % 4] = ref_mem[w_addr];
                end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
`ifdef GRID_RAM_ARBITER_STATS_EN
        n_checks++; if (stall_cnt !== 16'(e_stall)) begin n_errors++; $display("FAIL rnd_stall_cnt: got %0d want %0d", stall_cnt, e_stall); end
`endif
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_video_priority();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_raw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run still active at 2000000 ns, limit 2000000 ns");
        $fatal(1);
    end

endmodule
